// File: rtl/rx_frame_monitor.sv
`default_nettype none
// ============================================================================
// rx_frame_monitor: MAC RX frame tracker with per-frame record, statistics and
// RX config strobes. Define RX_FRAME_TIMESTAMP_EN for frame start timestamps.
// Revision: 1.0
// ============================================================================
module rx_frame_monitor #(
  parameter int LEN_W          = 14,
  parameter int STAT_W         = 32,
  parameter int MIN_LEN        = 64,
  parameter int MAX_LEN        = 1518,
  parameter int JUMBO_MAX_LEN  = 9018,
  parameter int JUMBO_EN       = 0,
  parameter int NO_CHK_CRC     = 0,
  parameter int STATUS_TIMEOUT = 16,
  parameter int TS_W           = 32
) (
  input  logic              rx_clk,
  input  logic              reset,
  output logic              conf_rx_en,
  output logic              conf_rx_no_chk_crc,
  output logic              conf_rx_jumbo_en,
  input  logic [7:0]        mac_rx_data,
  input  logic              mac_rx_dvld,
  input  logic              mac_rx_goodframe,
  input  logic              mac_rx_badframe,
  input  logic              clr_stats,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic [15:0]       frame_type,
  output logic              frame_good,
  output logic              frame_runt,
  output logic              frame_oversize,
  output logic              frame_timeout,
  output logic [TS_W-1:0]   frame_ts,
  output logic [STAT_W-1:0] good_cnt,
  output logic [STAT_W-1:0] bad_cnt,
  output logic [STAT_W-1:0] runt_cnt,
  output logic [STAT_W-1:0] oversize_cnt
);

  localparam int LW1 = LEN_W + 1;
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;
  localparam logic [LW1-1:0] OVERSIZE_THR = (JUMBO_EN != 0) ? LW1'(JUMBO_MAX_LEN) : LW1'(MAX_LEN);

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       type_q, type_d;
  logic [7:0]        wait_q, wait_d;
  logic              conf_rx_en_q, conf_rx_en_d;
  logic              frame_done_q, frame_done_d;
  logic [LEN_W-1:0]  frame_len_q, frame_len_d;
  logic [15:0]       frame_type_q, frame_type_d;
  logic              frame_good_q, frame_good_d;
  logic              frame_runt_q, frame_runt_d;
  logic              frame_oversize_q, frame_oversize_d;
  logic              frame_timeout_q, frame_timeout_d;
  logic [STAT_W-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [STAT_W-1:0] runt_cnt_q, runt_cnt_d, oversize_cnt_q, oversize_cnt_d;

  logic status_any, wait_expired, resolve, res_good, res_timeout, frame_start;
  logic res_runt, res_oversize, inc_good;

  assign status_any   = mac_rx_goodframe | mac_rx_badframe;
  assign wait_expired = ({1'b0, wait_q} + 9'd1) >= 9'(STATUS_TIMEOUT);
  assign res_runt     = {1'b0, len_q} < LW1'(MIN_LEN);
  assign res_oversize = {1'b0, len_q} > OVERSIZE_THR;
  assign inc_good     = res_good & ~res_runt & ~res_oversize;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  // A dvld in CHECK closes the pending frame and opens the next one at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  if (mac_rx_dvld) state_d = ST_DATA;
      ST_DATA:  if (!mac_rx_dvld) state_d = status_any ? ST_IDLE : ST_CHECK;
      ST_CHECK: begin
        if (mac_rx_dvld)                      state_d = ST_DATA;
        else if (status_any || wait_expired) state_d = ST_IDLE;
      end
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    len_d       = len_q;
    type_d      = type_q;
    wait_d      = wait_q;
    resolve     = 1'b0;
    res_good    = 1'b0;
    res_timeout = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      ST_IDLE: frame_start = mac_rx_dvld;
      ST_DATA: begin
        if (mac_rx_dvld) begin
          if (len_q != {LEN_W{1'b1}}) len_d = len_q + LEN_W'(1);
          if (len_q == LEN_W'(12)) type_d[15:8] = mac_rx_data;
          if (len_q == LEN_W'(13)) type_d[7:0]  = mac_rx_data;
        end else begin
          wait_d = 8'd0;
          if (status_any) begin
            resolve  = 1'b1;
            res_good = mac_rx_goodframe & ~mac_rx_badframe;
          end
        end
      end
      ST_CHECK: begin
        wait_d      = wait_q + 8'd1;
        frame_start = mac_rx_dvld;
        if (status_any) begin
          resolve  = 1'b1;
          res_good = mac_rx_goodframe & ~mac_rx_badframe;
        end else if (mac_rx_dvld || wait_expired) begin
          resolve     = 1'b1;
          res_timeout = 1'b1;
        end
      end
      default: ;
    endcase
    if (frame_start) begin
      len_d  = LEN_W'(1);
      type_d = 16'h0000;
    end

    conf_rx_en_d     = (state_d != ST_RESET);
    frame_done_d     = resolve;
    frame_len_d      = resolve ? len_q : frame_len_q;
    frame_type_d     = resolve ? ((len_q >= LEN_W'(14)) ? type_q : 16'h0000) : frame_type_q;
    frame_good_d     = resolve ? res_good : frame_good_q;
    frame_runt_d     = resolve ? res_runt : frame_runt_q;
    frame_oversize_d = resolve ? res_oversize : frame_oversize_q;
    frame_timeout_d  = resolve ? res_timeout : frame_timeout_q;

    // Clear wins over a coinciding resolution.
    good_cnt_d     = good_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    runt_cnt_d     = runt_cnt_q;
    oversize_cnt_d = oversize_cnt_q;
    if (clr_stats) begin
      good_cnt_d     = '0;
      bad_cnt_d      = '0;
      runt_cnt_d     = '0;
      oversize_cnt_d = '0;
    end else if (resolve) begin
      if (inc_good && good_cnt_q != '1)      good_cnt_d     = good_cnt_q + STAT_W'(1);
      if (!inc_good && bad_cnt_q != '1)      bad_cnt_d      = bad_cnt_q + STAT_W'(1);
      if (res_runt && runt_cnt_q != '1)      runt_cnt_d     = runt_cnt_q + STAT_W'(1);
      if (res_oversize && oversize_cnt_q != '1) oversize_cnt_d = oversize_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      len_q            <= '0;
      type_q           <= '0;
      wait_q           <= '0;
      conf_rx_en_q     <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_len_q      <= '0;
      frame_type_q     <= '0;
      frame_good_q     <= 1'b0;
      frame_runt_q     <= 1'b0;
      frame_oversize_q <= 1'b0;
      frame_timeout_q  <= 1'b0;
      good_cnt_q       <= '0;
      bad_cnt_q        <= '0;
      runt_cnt_q       <= '0;
      oversize_cnt_q   <= '0;
    end else begin
      len_q            <= len_d;
      type_q           <= type_d;
      wait_q           <= wait_d;
      conf_rx_en_q     <= conf_rx_en_d;
      frame_done_q     <= frame_done_d;
      frame_len_q      <= frame_len_d;
      frame_type_q     <= frame_type_d;
      frame_good_q     <= frame_good_d;
      frame_runt_q     <= frame_runt_d;
      frame_oversize_q <= frame_oversize_d;
      frame_timeout_q  <= frame_timeout_d;
      good_cnt_q       <= good_cnt_d;
      bad_cnt_q        <= bad_cnt_d;
      runt_cnt_q       <= runt_cnt_d;
      oversize_cnt_q   <= oversize_cnt_d;
    end
  end

`ifdef RX_FRAME_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, start_ts_q, start_ts_d, frame_ts_q, frame_ts_d;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    start_ts_d = frame_start ? ts_q : start_ts_q;
    frame_ts_d = resolve ? start_ts_q : frame_ts_q;
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      start_ts_q <= '0;
      frame_ts_q <= '0;
    end else begin
      ts_q       <= ts_d;
      start_ts_q <= start_ts_d;
      frame_ts_q <= frame_ts_d;
    end
  end

  assign frame_ts = frame_ts_q;
`else
  assign frame_ts = '0;
`endif

  assign conf_rx_en         = conf_rx_en_q;
  assign conf_rx_no_chk_crc = (NO_CHK_CRC != 0);
  assign conf_rx_jumbo_en   = (JUMBO_EN != 0);
  assign frame_done         = frame_done_q;
  assign frame_len          = frame_len_q;
  assign frame_type         = frame_type_q;
  assign frame_good         = frame_good_q;
  assign frame_runt         = frame_runt_q;
  assign frame_oversize     = frame_oversize_q;
  assign frame_timeout      = frame_timeout_q;
  assign good_cnt           = good_cnt_q;
  assign bad_cnt            = bad_cnt_q;
  assign runt_cnt           = runt_cnt_q;
  assign oversize_cnt       = oversize_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rx_frame_monitor: transaction-level expectations checked every cycle.
// Revision: 1.0
// ============================================================================
module tb_rx_frame_monitor;
  localparam int T = 16;

  logic rx_clk = 1'b0, reset = 1'b1;
  logic [7:0] mac_rx_data = 8'h00;
  logic mac_rx_dvld = 1'b0, mac_rx_goodframe = 1'b0, mac_rx_badframe = 1'b0, clr_stats = 1'b0;

  logic conf_rx_en, conf_rx_no_chk_crc, conf_rx_jumbo_en, frame_done;
  logic [13:0] frame_len;
  logic [15:0] frame_type;
  logic frame_good, frame_runt, frame_oversize, frame_timeout;
  logic [31:0] frame_ts, good_cnt, bad_cnt, runt_cnt, oversize_cnt;

  logic j_conf_rx_en, j_no_chk_crc, j_jumbo_en, j_frame_done;
  logic [13:0] j_frame_len;
  logic [15:0] j_frame_type;
  logic j_frame_good, j_frame_runt, j_frame_oversize, j_frame_timeout;
  logic [31:0] j_frame_ts, j_good_cnt, j_bad_cnt, j_runt_cnt, j_oversize_cnt;

  rx_frame_monitor dut (
    .rx_clk(rx_clk), .reset(reset), .conf_rx_en(conf_rx_en),
    .conf_rx_no_chk_crc(conf_rx_no_chk_crc), .conf_rx_jumbo_en(conf_rx_jumbo_en),
    .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
    .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
    .clr_stats(clr_stats), .frame_done(frame_done), .frame_len(frame_len),
    .frame_type(frame_type), .frame_good(frame_good), .frame_runt(frame_runt),
    .frame_oversize(frame_oversize), .frame_timeout(frame_timeout), .frame_ts(frame_ts),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .runt_cnt(runt_cnt), .oversize_cnt(oversize_cnt)
  );

  rx_frame_monitor #(.JUMBO_EN(1)) dut_jumbo (
    .rx_clk(rx_clk), .reset(reset), .conf_rx_en(j_conf_rx_en),
    .conf_rx_no_chk_crc(j_no_chk_crc), .conf_rx_jumbo_en(j_jumbo_en),
    .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
    .mac_rx_goodframe(mac_rx_goodframe), .mac_rx_badframe(mac_rx_badframe),
    .clr_stats(clr_stats), .frame_done(j_frame_done), .frame_len(j_frame_len),
    .frame_type(j_frame_type), .frame_good(j_frame_good), .frame_runt(j_frame_runt),
    .frame_oversize(j_frame_oversize), .frame_timeout(j_frame_timeout), .frame_ts(j_frame_ts),
    .good_cnt(j_good_cnt), .bad_cnt(j_bad_cnt), .runt_cnt(j_runt_cnt), .oversize_cnt(j_oversize_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    int at; int len; logic [15:0] typ;
    bit good; bit runt; bit over; bit jover; bit tmo; logic [31:0] ts;
  } rec_t;

  rec_t expq[$];
  rec_t cur;
  int cyc = 0;
  int checks = 0, failures = 0;
  int m_good = 0, m_bad = 0, m_runt = 0, m_over = 0, mj_good = 0;
  int done_cyc = -1, done_seen = 0, last_fall = 0, last_start = 0;
  bit ed;

  // cyc equals the number of clock edges since reset release: the timestamp value.
  always @(posedge rx_clk or posedge reset)
    if (reset) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge rx_clk) begin
    #2;
    if (!reset) begin
      while (expq.size() > 0 && expq[0].at < cyc) void'(expq.pop_front());
      ed = (expq.size() > 0 && expq[0].at == cyc);
      if (ed) cur = expq.pop_front();
      if (clr_stats) begin
        m_good = 0; m_bad = 0; m_runt = 0; m_over = 0; mj_good = 0;
      end else if (ed) begin
        if (cur.good && !cur.runt && !cur.over) m_good++; else m_bad++;
        if (cur.runt) m_runt++;
        if (cur.over) m_over++;
        if (cur.good && !cur.runt && !cur.jover) mj_good++;
      end
      if (frame_done === 1'b1) begin done_cyc = cyc; done_seen++; end
      chk("frame_done", frame_done, ed);
      chk("frame_len", frame_len, cur.len);
      chk("frame_type", frame_type, cur.typ);
      chk("frame_good", frame_good, cur.good);
      chk("frame_runt", frame_runt, cur.runt);
      chk("frame_oversize", frame_oversize, cur.over);
      chk("frame_timeout", frame_timeout, cur.tmo);
      chk("frame_ts", frame_ts, cur.ts);
      chk("good_cnt", good_cnt, m_good);
      chk("bad_cnt", bad_cnt, m_bad);
      chk("runt_cnt", runt_cnt, m_runt);
      chk("oversize_cnt", oversize_cnt, m_over);
      chk("conf_rx_en", conf_rx_en, 1);
      chk("jumbo_frame_done", j_frame_done, ed);
      chk("jumbo_frame_oversize", j_frame_oversize, cur.jover);
      chk("jumbo_good_cnt", j_good_cnt, mj_good);
    end
  end

  task automatic do_reset(input int hold);
    @(negedge rx_clk);
    reset = 1'b1; mac_rx_dvld = 1'b0; mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0; clr_stats = 1'b0;
    expq.delete();
    cur = '{default: 0};
    m_good = 0; m_bad = 0; m_runt = 0; m_over = 0; mj_good = 0; done_seen = 0;
    #1;
    chk("reset_frame_done", frame_done, 0);
    chk("reset_conf_rx_en", conf_rx_en, 0);
    chk("reset_frame_len", frame_len, 0);
    chk("reset_good_cnt", good_cnt, 0);
    chk("reset_bad_cnt", bad_cnt, 0);
    repeat (hold) @(negedge rx_clk);
    reset = 1'b0;
    #1 chk("conf_rx_en_after_release", conf_rx_en, 0);
    @(negedge rx_clk);
  endtask

  // Status (if any) is driven on idle slot d; the next frame starts after gap idle slots.
  task automatic run_frame(input int len, input logic [7:0] b12, input logic [7:0] b13,
                           input bit sg, input bit sb, input int d, input int gap, input int clr_at);
    rec_t r;
    bit st_ok;
    for (int i = 0; i < len; i++) begin
      @(negedge rx_clk);
      if (i == 0) last_start = cyc;
      mac_rx_dvld = 1'b1;
      mac_rx_data = (i == 12) ? b12 : (i == 13) ? b13 : 8'($urandom);
      mac_rx_goodframe = (i > 0) && ($urandom_range(0, 15) == 0);
      mac_rx_badframe  = (i > 0) && ($urandom_range(0, 15) == 0);
      clr_stats = 1'b0;
    end
    last_fall = last_start + len;
    st_ok   = (sg || sb) && (d < gap) && (d <= T);
    r.at    = last_fall + 1 + (st_ok ? d : ((gap < T) ? gap : T));
    r.len   = len;
    r.typ   = (len >= 14) ? {b12, b13} : 16'h0000;
    r.good  = st_ok && sg && !sb;
    r.runt  = (len < 64);
    r.over  = (len > 1518);
    r.jover = (len > 9018);
    r.tmo   = !st_ok;
`ifdef RX_FRAME_TIMESTAMP_EN
    r.ts    = last_start;
`else
    r.ts    = 0;
`endif
    expq.push_back(r);
    for (int k = 0; k < gap; k++) begin
      @(negedge rx_clk);
      mac_rx_dvld = 1'b0;
      mac_rx_data = 8'($urandom);
      mac_rx_goodframe = sg && (k == d);
      mac_rx_badframe  = sb && (k == d);
      clr_stats = (k == clr_at);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int blens[7];
    blens = '{13, 14, 63, 64, 1518, 1519, 1};
    cur = '{default: 0};
    do_reset(3);
    chk("no_chk_crc_const", conf_rx_no_chk_crc, 0);
    chk("jumbo_en_const", conf_rx_jumbo_en, 0);
    chk("jumbo_en_const_j", j_jumbo_en, 1);

    run_frame(64, 8'h08, 8'h00, 1, 0, 2, 20, -1);
    chk("t1_len", frame_len, 64);
    chk("t1_type", frame_type, 16'h0800);
    chk("t1_good", frame_good, 1);
    chk("t1_latency", done_cyc - last_fall, 3);
    chk("t1_good_cnt", good_cnt, 1);
`ifdef RX_FRAME_TIMESTAMP_EN
    chk("t1_ts", frame_ts, last_start);
`endif

    run_frame(20, 8'h11, 8'h22, 0, 1, 1, 20, -1);
    chk("t2_runt", frame_runt, 1);
    chk("t2_good", frame_good, 0);
    chk("t2_bad_cnt", bad_cnt, 1);
    chk("t2_runt_cnt", runt_cnt, 1);

    run_frame(1600, 8'h86, 8'hdd, 1, 0, 1, 20, -1);
    chk("t3_oversize", frame_oversize, 1);
    chk("t3_bad_cnt", bad_cnt, 2);
    chk("t3_oversize_cnt", oversize_cnt, 1);
    chk("t3_jumbo_oversize", j_frame_oversize, 0);
    chk("t3_jumbo_good_cnt", j_good_cnt, 2);

    run_frame(100, 8'h08, 8'h06, 0, 0, 0, T + 8, -1);
    chk("t4_timeout", frame_timeout, 1);
    chk("t4_good", frame_good, 0);
    chk("t4_latency", done_cyc - last_fall, T + 1);
    chk("t4_bad_cnt", bad_cnt, 3);

    run_frame(100, 8'h08, 8'h06, 1, 1, 1, 20, -1);
    chk("t5_good", frame_good, 0);
    chk("t5_timeout", frame_timeout, 0);
    chk("t5_bad_cnt", bad_cnt, 4);

    run_frame(50, 8'h12, 8'h34, 0, 0, 0, 5, -1);
    run_frame(64, 8'h56, 8'h78, 1, 0, 1, 20, -1);
    chk("t6_len", frame_len, 64);
    chk("t6_good_cnt", good_cnt, 2);
    chk("t6_bad_cnt", bad_cnt, 5);
    chk("t6_runt_cnt", runt_cnt, 2);

    for (int i = 0; i < 30; i++) begin
      @(negedge rx_clk);
      mac_rx_dvld = 1'b1; mac_rx_data = 8'($urandom);
      mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0;
    end
    do_reset(2);
    run_frame(64, 8'h08, 8'h00, 1, 0, 2, 20, -1);
    chk("t7_done_count", done_seen, 1);
    chk("t7_len", frame_len, 64);
    chk("t7_good_cnt", good_cnt, 1);

    run_frame(64, 8'h08, 8'h00, 1, 0, 2, 20, 3);
    chk("t8_good_cnt_clr", good_cnt, 0);
    chk("t8_bad_cnt_clr", bad_cnt, 0);
    run_frame(20, 8'h08, 8'h00, 0, 1, 0, 20, 0);
    chk("t8_runt_flag", frame_runt, 1);
    chk("t8_runt_cnt_clr", runt_cnt, 0);
    chk("t8_bad_cnt_clr2", bad_cnt, 0);

    foreach (blens[i])
      run_frame(blens[i], 8'($urandom), 8'($urandom), 1, 0, 1, 20, -1);
    run_frame(9018, 8'h88, 8'h70, 1, 0, 1, 20, -1);
    chk("t9_jumbo_9018", j_frame_oversize, 0);
    run_frame(9019, 8'h88, 8'h70, 1, 0, 1, 20, -1);
    chk("t9_jumbo_9019", j_frame_oversize, 1);

    for (int n = 0; n < 30; n++) begin
      int len, d, gap, ca;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 1600));
      d   = $urandom_range(0, T + 3);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T + 2)) : int'($urandom_range(T + 2, T + 6));
      ca  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, gap - 1)) : -1;
      run_frame(len, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), d, gap, ca);
    end

    @(negedge rx_clk);
    mac_rx_dvld = 1'b0; mac_rx_goodframe = 1'b0; mac_rx_badframe = 1'b0; clr_stats = 1'b0;
    repeat (T + 4) @(negedge rx_clk);
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_frame_monitor.md
# rx_frame_monitor

Parametrised receive-side frame monitor on the MAC client RX interface, in the rx_clk domain. Tracks each frame through IDLE/DATA/CHECK, measures length, captures the EtherType and resolves MAC good/bad status with a timeout. Emits a one-cycle per-frame completion record, keeps saturating statistics counters and drives the MAC RX configuration strobes.

## Interface
- LEN_W, 14: frame length counter width; saturates at 2^LEN_W-1.
- STAT_W, 32: statistics counter width.
- MIN_LEN, 64: frames shorter than this are runts.
- MAX_LEN, 1518: oversize threshold with jumbo disabled.
- JUMBO_MAX_LEN, 9018: oversize threshold with jumbo enabled.
- JUMBO_EN, 0: drives conf_rx_jumbo_en; selects the threshold.
- NO_CHK_CRC, 0: drives conf_rx_no_chk_crc.
- STATUS_TIMEOUT, 16: CHECK cycles allowed for status, 1..255.
- TS_W, 32: timestamp width.

Ports:
- rx_clk in 1: clock.
- reset in 1: asynchronous, active-high.
- conf_rx_en out 1: MAC RX enable. Registered, 0 in RESET state, 1 otherwise.
- conf_rx_no_chk_crc out 1: constant NO_CHK_CRC.
- conf_rx_jumbo_en out 1: constant JUMBO_EN.
- mac_rx_data in 8: RX byte.
- mac_rx_dvld in 1: byte valid.
- mac_rx_goodframe in 1: good-frame status pulse.
- mac_rx_badframe in 1: bad-frame status pulse.
- clr_stats in 1: synchronous clear of all statistics.
- frame_done out 1: one-cycle completion pulse.
- frame_len out LEN_W: byte count.
- frame_type out 16: bytes 12 (MSB) and 13 (LSB).
- frame_good, frame_runt, frame_oversize, frame_timeout out 1 each: per-frame flags.
- frame_ts out TS_W: start timestamp.
- good_cnt, bad_cnt, runt_cnt, oversize_cnt out STAT_W: statistics.

## Operation
- States: RESET, IDLE, DATA, CHECK.
- RESET: entered asynchronously on reset. Moves to IDLE on the first clock after deassertion.
- IDLE: when dvld=1, go to DATA. Set len=1 and byte index 1; the byte is index 0.
- DATA: each dvld cycle increments len (saturating) and the index. Bytes at index 12 and 13 load frame_type[15:8] and frame_type[7:0]. Frames shorter than 14 bytes report frame_type=0.
- DATA, dvld=0: if good or bad status is present in the same cycle, resolve immediately. Otherwise go to CHECK with the wait counter cleared.
- CHECK: the first good or bad pulse resolves the frame; if both are high, bad wins. If the wait counter reaches STATUS_TIMEOUT with no status, resolve with frame_timeout=1 and frame_good=0.
- CHECK with dvld=1 before any status: resolve the pending frame as a timeout. In the same cycle, start a new frame in DATA with len=1.
- After resolution, return to IDLE (or DATA, per the rule above).
- Flags: runt = len<MIN_LEN. oversize = len > (JUMBO_EN ? JUMBO_MAX_LEN : MAX_LEN). Compare at LEN_W+1 bits.
- Statistics:
  - good_cnt increments when the status is good and the frame is neither runt nor oversize.
  - bad_cnt increments for every other frame, including timeouts.
  - runt_cnt and oversize_cnt increment on their flags.
  - All counters saturate at all-ones.
- clr_stats zeroes all four counters. It takes priority over a coinciding frame_done, so that frame is not counted.
- Status pulses seen in IDLE or DATA (dvld=1) are ignored.

## Timing
- frame_done is registered and asserts the cycle after resolution. The frame_* outputs update in that same cycle and hold until the next frame_done.
- Statistics counters update in the same cycle as frame_done.
- Reset values: state RESET, conf_rx_en 0, frame_done 0, all frame_* 0, all counters 0, timestamp counter 0.
- Reset mid-frame: the frame is discarded and no frame_done is produced.
- Latency from last dvld to frame_done is 1 + status wait cycles, with a maximum of STATUS_TIMEOUT+1.
- Back-to-back frames need at least one dvld=0 cycle between them (MAC guarantee).

## Configuration
- RX_FRAME_TIMESTAMP_EN defined:
  - A free-running TS_W counter runs from reset and wraps modulo 2^TS_W.
  - Its value in the cycle the first dvld is sampled is latched.
  - The latched value is presented on frame_ts with frame_done.
- RX_FRAME_TIMESTAMP_EN undefined: no counter is built and frame_ts is tied to 0.

## Test plan
- 64-byte frame, bytes 12/13 = 0x08/0x00, goodframe 2 cycles after dvld falls:
  - frame_done 3 cycles after dvld falls, with len=64, type=0x0800, good=1.
  - good_cnt=1.
- 20-byte frame followed by badframe: runt=1, good=0, bad_cnt=1, runt_cnt=1.
- 1600-byte good frame: with JUMBO_EN=0, oversize=1 and bad_cnt increments. With JUMBO_EN=1, oversize=0 and good_cnt increments.
- No status after 100-byte frame:
  - frame_done exactly STATUS_TIMEOUT+1 cycles after dvld falls, with timeout=1.
  - With goodframe and badframe high together instead: good=0.
- Reset asserted at byte 30 of a frame, then a 64-byte good frame:
  - conf_rx_en=0 for 1 cycle after deassert.
  - Only one frame_done, len=64.
- clr_stats coincident with frame_done: all counters read 0 next cycle.
- With the macro defined: frame_ts equals the cycle index of the first dvld.
